shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the ALU-side shifter: decodes MIPS shift/LUI instructions, shifts
//  one bit per clock for the required amount, and stalls the pipeline until the result is ready.
//  Sits beside the ALU in EX. Its result replaces the ALU output when a shift completes.
//  Replaces a single-cycle barrel shift with an iterative, area-cheap one.
// PARAMETERS
//  W   32  datapath width (>= 17, so the LUI shift is representable)
// PORTS
//  clk       in   1   single clock, rising edge
//  rst       in   1   asynchronous, active-high reset
//  start     in   1   EX-stage instruction valid; request a shift
//  opcode    in   6   instruction[31:26]
//  funct     in   6   instruction[5:0]
//  shamt     in   5   instruction[10:6], constant shift amount
//  var_amt   in   W   rs value; bits [4:0] are the variable shift amount
//  data_in   in   W   operand: rt value, or zero-extended imm16 for LUI
//  is_shift  out  1   combinational: opcode/funct decode to a supported shift
//  stall     out  1   combinational: hold IF/ID/EX this cycle
//  busy      out  1   state == SHIFT
//  done      out  1   one-cycle pulse: result valid
//  result    out  W   shifted value, held until the next accepted start
// BEHAVIOUR
//  Decode (opcode 0x00 unless noted):
//   funct 0x00 SLL, 0x02 SRL, 0x03 SRA: amount = shamt
//   funct 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: amount = var_amt[4:0]
//   opcode 0x0F LUI: left shift, amount = 16
//   all other combinations: is_shift = 0
//  Directions: left fills with 0; SRL fills with 0; SRA replicates the latched sign bit every step.
//  accept = start & is_shift & (state == IDLE | state == DONE)
//  States: IDLE, SHIFT, DONE.
//   IDLE/DONE + accept: acc <= data_in, cnt <= amount, latch kind;
//     next state = (amount == 0) ? DONE : SHIFT.
//   IDLE/DONE, no accept: next state = IDLE.
//   SHIFT: acc shifted by 1, cnt <= cnt - 1; if cnt == 1, go to DONE.
//   DONE: done = 1 for this cycle only; result = acc.
//  Latency: start sampled in cycle 0 -> done in cycle N+1 (N = amount, 0..31).
//  stall = accept | (state == SHIFT). Stall is low in the DONE cycle, so the pipeline advances
//  with the result.
//  Back-to-back: an accept in the DONE cycle starts the next op. done still pulses for the
//  finishing op that cycle.
//  start while SHIFT, or start with is_shift = 0: ignored; no state or output change.
//  cnt is 5 bits and never wraps, because it is decremented only while cnt >= 1.
//  var_amt[W-1:5] is ignored.
//  result updates only on entry to DONE; it holds its value through IDLE and SHIFT.
//  Reset (asynchronous, any time, including mid-SHIFT): state = IDLE, acc = 0, cnt = 0,
//  result = 0, done = 0, busy = 0. The in-flight op is dropped; no done pulse.
// STRUCTURE
//  Shared package mips_defs: OP_RTYPE = 6'h00, OP_LUI = 6'h0F, FN_SLL/SRL/SRA/SLLV/SRLV/SRAV
//  localparams, and a 2-bit shift-kind encoding (LEFT, LOGIC_RIGHT, ARITH_RIGHT).
//  State encoding is local.
//  Sub-module shift_decode: combinational. (opcode, funct, shamt, var_amt[4:0]) ->
//  (is_shift, kind, amount). Reused by the hazard unit.
//  Top level holds the FSM, acc/cnt registers, and the 1-bit shift step.
// TESTING
//  1. SLL, data_in = 32'h0000_0001, shamt = 4 -> done in cycle 5, result = 32'h0000_0010;
//     stall high in cycles 0-4.
//  2. SRA, data_in = 32'h8000_0000, shamt = 31 -> done in cycle 32, result = 32'hFFFF_FFFF.
//     SRL with the same inputs -> result = 32'h0000_0001.
//  3. LUI, data_in = 32'h0000_ABCD -> done in cycle 17, result = 32'hABCD_0000.
//     SRLV, var_amt = 32'hFFFF_FFE8 (amount 8), data_in = 32'hFF00_0000 -> result = 32'h00FF_0000.
//  4. SLL, shamt = 0, data_in = 32'h1234_5678 -> done in cycle 1, result unchanged.
//     Then a non-shift instruction (funct 0x20) -> is_shift = 0, stall = 0, no done.
//  5. Back-to-back: second SLL, amount 2, raised in the first op's DONE cycle -> accepted.
//     Two done pulses 3 cycles apart. A start during SHIFT is ignored.
//  6. Assert rst mid-SHIFT (cycle 3 of a 10-step op) -> outputs go to 0 at once; IDLE after
//     release; no done pulse. A fresh op afterwards completes correctly.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS decode constants and the shift-kind encoding used by the
// shifter decode and sequencer (and by the hazard unit).
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;

    // LUI places imm16 in the upper half: a fixed 16-bit left shift.
    localparam logic [4:0] LUI_AMOUNT = 5'd16;

    typedef enum logic [1:0] {
        KIND_LEFT        = 2'd0,
        KIND_LOGIC_RIGHT = 2'd1,
        KIND_ARITH_RIGHT = 2'd2
    } shift_kind_e;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of MIPS shift/LUI instructions into
// (is_shift, kind, amount). Shared with the hazard unit.
module shift_decode
    import mips_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] shamt,
    input  logic [4:0] var_amt,
    output logic       is_shift,
    output logic [1:0] kind,
    output logic [4:0] amount
);

    // Classify the instruction and select constant vs register shift amount.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        is_shift = 1'b0;
        kind     = KIND_LEFT;
        amount   = 5'd0;
        if (opcode == OP_LUI) begin
            is_shift = 1'b1;
            kind     = KIND_LEFT;
            amount   = LUI_AMOUNT;
        end else if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SLL:  begin is_shift = 1'b1; kind = KIND_LEFT;        amount = shamt;   end
                FN_SRL:  begin is_shift = 1'b1; kind = KIND_LOGIC_RIGHT; amount = shamt;   end
                FN_SRA:  begin is_shift = 1'b1; kind = KIND_ARITH_RIGHT; amount = shamt;   end
                FN_SLLV: begin is_shift = 1'b1; kind = KIND_LEFT;        amount = var_amt; end
                FN_SRLV: begin is_shift = 1'b1; kind = KIND_LOGIC_RIGHT; amount = var_amt; end
                FN_SRAV: begin is_shift = 1'b1; kind = KIND_ARITH_RIGHT; amount = var_amt; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Iterative one-bit-per-clock shifter sequencer for the EX stage.
// Accepts a shift/LUI, stalls the pipeline while shifting, and pulses
// done for one cycle with the result held in a register.
module shift_seq_ctrl
    import mips_defs::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    input  logic [4:0]   shamt,
    input  logic [W-1:0] var_amt,
    input  logic [W-1:0] data_in,
    output logic         is_shift,
    output logic         stall,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    logic [4:0]   cnt_q, cnt_d;
    shift_kind_e  kind_q, kind_d;
    logic [W-1:0] result_q, result_d;

    logic [1:0]   dec_kind;
    logic [4:0]   dec_amount;
    logic [W-1:0] acc_step;
    logic         accept;

    // Only the low five bits of the register operand encode an amount.
    logic         var_amt_unused;
    assign var_amt_unused = ^var_amt[W-1:5];

    shift_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .shamt    (shamt),
        .var_amt  (var_amt[4:0]),
        .is_shift (is_shift),
        .kind     (dec_kind),
        .amount   (dec_amount)
    );

    // A new op may only be taken when idle or while finishing the previous one.
    assign accept = start & is_shift & ((state_q == S_IDLE) | (state_q == S_DONE));

    // One-bit shift of the accumulator; SRA re-copies the MSB, which holds
    // the sign latched at accept because the MSB is never overwritten.
    always_comb begin
        acc_step = acc_q;
        case (kind_q)
            KIND_LEFT:        acc_step = {acc_q[W-2:0], 1'b0};
            KIND_LOGIC_RIGHT: acc_step = {1'b0, acc_q[W-1:1]};
            KIND_ARITH_RIGHT: acc_step = {acc_q[W-1], acc_q[W-1:1]};
            default:          acc_step = acc_q;
        endcase
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    acc_d  = data_in;
                    cnt_d  = dec_amount;
                    kind_d = shift_kind_e'(dec_kind);
                    if (dec_amount == 5'd0) begin
                        // Zero-length op goes straight to DONE with the operand.
                        state_d  = S_DONE;
                        result_d = data_in;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                acc_d = acc_step;
                // cnt is at least 1 here, so it cannot wrap.
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d  = S_DONE;
                    result_d = acc_step;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its _d value from before the edge.
        if (rst) begin
            // NOTE: all registers here are plain flops (no memory arrays),
            // so each one is cleared to a defined value by reset.
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= 5'd0;
            kind_q   <= KIND_LEFT;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_SHIFT);
    assign done   = (state_q == S_DONE);
    assign stall  = accept | busy;
    assign result = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases plus randomized
// ops compared against an arithmetic reference model.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] var_amt;
    logic [31:0] data_in;
    logic        is_shift;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_held = 32'h0;

    shift_seq_ctrl #(.W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .funct    (funct),
        .shamt    (shamt),
        .var_amt  (var_amt),
        .data_in  (data_in),
        .is_shift (is_shift),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: instruction semantics as plain arithmetic.
    function automatic bit model_valid(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h0F) return 1'b1;
        if (op != 6'h00) return 1'b0;
        return (fn == 6'h00) || (fn == 6'h02) || (fn == 6'h03) ||
               (fn == 6'h04) || (fn == 6'h06) || (fn == 6'h07);
    endfunction

    function automatic int model_amount(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [4:0] sa, input logic [31:0] va);
        if (op == 6'h0F) return 16;
        if (fn == 6'h04 || fn == 6'h06 || fn == 6'h07) return int'(va[4:0]);
        return int'(sa);
    endfunction

    function automatic logic [31:0] model_result(input logic [5:0] op, input logic [5:0] fn,
                                                 input logic [4:0] sa, input logic [31:0] va,
                                                 input logic [31:0] d);
        int amt;
        amt = model_amount(op, fn, sa, va);
        if (op == 6'h0F) return d << 16;
        case (fn)
            6'h02, 6'h06: return d >> amt;
            6'h03, 6'h07: return 32'($signed(d) >>> amt);
            default:      return d << amt;
        endcase
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sa,
                         input logic [31:0] va, input logic [31:0] d);
        opcode  = op;
        funct   = fn;
        shamt   = sa;
        var_amt = va;
        data_in = d;
        start   = 1'b1;
    endtask

    // Issue one valid op from idle and check stall window, latency and result.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] sa, input logic [31:0] va, input logic [31:0] d);
        logic [31:0] exp_r;
        int n;
        int k;
        int stall_bad;
        bit seen;
        exp_r = model_result(op, fn, sa, va, d);
        n = model_amount(op, fn, sa, va);
        @(negedge clk);
        drive(op, fn, sa, va, d);
        #1;
        check({tag, ":is_shift"}, is_shift, 1);
        check({tag, ":stall_c0"}, stall, 1);
        @(posedge clk);
        #1 start = 1'b0;
        k = 1;
        seen = 1'b0;
        stall_bad = 0;
        while (!seen && k <= 40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                if (!stall || !busy) stall_bad++;
                k++;
            end
        end
        check({tag, ":done_seen"}, seen, 1);
        check({tag, ":done_cycle"}, k, n + 1);
        check({tag, ":result"}, result, exp_r);
        check({tag, ":stall_done"}, stall, 0);
        check({tag, ":stall_window"}, stall_bad, 0);
        exp_held = exp_r;
        @(negedge clk);
        check({tag, ":done_pulse"}, done, 0);
    endtask

    // Present a non-shift instruction and confirm it is ignored.
    task automatic run_invalid(input string tag, input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        drive(op, fn, 5'd3, 32'h0000_0005, 32'hA5A5_A5A5);
        #1;
        check({tag, ":is_shift"}, is_shift, 0);
        check({tag, ":stall"}, stall, 0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check({tag, ":busy"}, busy, 0);
        check({tag, ":done"}, done, 0);
        check({tag, ":result_held"}, result, exp_held);
    endtask

    initial begin
        int k;
        int dones;
        bit seen;
        logic [5:0] bad_fn [6];
        bad_fn = '{6'h20, 6'h21, 6'h01, 6'h05, 6'h08, 6'h2A};

        rst = 1'b1;
        start = 1'b0;
        opcode = 6'h00;
        funct = 6'h00;
        shamt = 5'd0;
        var_amt = 32'h0;
        data_in = 32'h0;
        repeat (2) @(negedge clk);
        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        check("reset:result", result, 0);
        check("reset:stall", stall, 0);
        rst = 1'b0;

        // Directed cases.
        run_op("sll4",   6'h00, 6'h00, 5'd4,  32'h0,         32'h0000_0001);
        run_op("sra31",  6'h00, 6'h03, 5'd31, 32'h0,         32'h8000_0000);
        run_op("srl31",  6'h00, 6'h02, 5'd31, 32'h0,         32'h8000_0000);
        run_op("lui",    6'h0F, 6'h15, 5'd0,  32'h0,         32'h0000_ABCD);
        run_op("srlv8",  6'h00, 6'h06, 5'd0,  32'hFFFF_FFE8, 32'hFF00_0000);
        run_op("sll0",   6'h00, 6'h00, 5'd0,  32'h0,         32'h1234_5678);
        run_invalid("add", 6'h00, 6'h20);

        // Back-to-back: second op accepted in the first op's DONE cycle.
        @(negedge clk);
        drive(6'h00, 6'h00, 5'd3, 32'h0, 32'h0000_0001);
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
        end
        check("b2b:first_done", seen, 1);
        drive(6'h00, 6'h00, 5'd2, 32'h0, 32'h0000_0003);
        #1;
        check("b2b:first_result", result, 32'h0000_0008);
        check("b2b:accept_stall", stall, 1);
        check("b2b:done_with_accept", done, 1);
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
        end
        check("b2b:gap", k, 3);
        check("b2b:second_result", result, 32'h0000_000C);
        exp_held = 32'h0000_000C;
        @(negedge clk);

        // Start during SHIFT is ignored.
        @(negedge clk);
        drive(6'h00, 6'h02, 5'd6, 32'h0, 32'hF000_0000);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        drive(6'h00, 6'h00, 5'd0, 32'h0, 32'h0000_DEAD);
        #1;
        check("ign:busy", busy, 1);
        check("ign:stall", stall, 1);
        @(posedge clk);
        #1 start = 1'b0;
        k = 2;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
        end
        check("ign:done_cycle", k, 7);
        check("ign:result", result, 32'h03C0_0000);
        exp_held = 32'h03C0_0000;
        @(negedge clk);

        // Asynchronous reset in cycle 3 of a 10-step op.
        @(negedge clk);
        drive(6'h00, 6'h00, 5'd10, 32'h0, 32'h0000_0001);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:result", result, 0);
        check("rst:stall", stall, 0);
        exp_held = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst:no_done", dones, 0);
        check("rst:idle", busy, 0);
        run_op("post_rst", 6'h00, 6'h07, 5'd0, 32'h0000_0025, 32'h8765_4321);

        // Randomized ops against the reference model.
        for (int r = 0; r < 24; r++) begin
            int sel;
            logic [5:0] op;
            logic [5:0] fn;
            logic [31:0] d;
            sel = $urandom_range(0, 7);
            d = $urandom;
            op = 6'h00;
            case (sel)
                0: fn = 6'h00;
                1: fn = 6'h02;
                2: fn = 6'h03;
                3: fn = 6'h04;
                4: fn = 6'h06;
                5: fn = 6'h07;
                6: begin op = 6'h0F; fn = 6'($urandom); d = d & 32'h0000_FFFF; end
                default: fn = bad_fn[$urandom_range(0, 5)];
            endcase
            if (model_valid(op, fn))
                run_op($sformatf("rnd%0d", r), op, fn, 5'($urandom), $urandom, d);
            else
                run_invalid($sformatf("rnd%0d_bad", r), op, fn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
